multimaster_bus_controller: RTL and testbench

- Parametrised N-master, single-slave-port system bus controller.
- Arbitrates among NMASTERS requesters (fixed-priority or round-robin) and muxes the winner onto the shared bus.
- Sequences start/wait-state/complete phases, with slave-extended waits, decode-miss and timeout error reporting.
- Sits between the CPU/VGA/DMA masters and an external address decoder plus slave peripherals.

---
 rtl/multimaster_bus_controller.sv | 187 ++++++++++++++++++
 tb/tb_multimaster_bus_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multimaster_bus_controller.sv
// N-master, single-slave-port bus controller: arbitrates requesters (fixed or
// round-robin), muxes the winner onto the bus and sequences START/PRE/POST/ERR.
module multimaster_bus_controller #(
  parameter int NMASTERS    = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NCS         = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int RR          = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NMASTERS*AW-1:0]   m_address,
  input  logic [NMASTERS-1:0]      m_read,
  input  logic [NMASTERS-1:0]      m_write,
  input  logic [NMASTERS*DW/8-1:0] m_be,
  input  logic [NMASTERS*DW-1:0]   m_writedata,
  output logic [NMASTERS-1:0]      m_wait,
  output logic [NMASTERS-1:0]      m_error,
  output logic [AW-1:0]            address,
  output logic                     read,
  output logic                     write,
  output logic [DW/8-1:0]          be,
  output logic [DW-1:0]            writedata,
  output logic                     start,
  output logic [NCS-1:0]           chipselect,
  input  logic [NCS-1:0]           decode_cs,
  input  logic                     slave_wait,
  output logic [NMASTERS-1:0]      grant
);
  localparam int PW = $clog2(NMASTERS);
  localparam int BW = DW / 8;

  typedef enum logic [2:0] {IDLE, START, PRE, POST, ERR} state_t;

  state_t              state_reg, state_next;
  logic [NMASTERS-1:0] grant_reg, grant_next;
  logic [3:0]          delay_reg, delay_next;
  logic [7:0]          timer_reg, timer_next;
  logic [PW-1:0]       ptr_reg, ptr_next;

  logic [NMASTERS-1:0] req;
  logic                any_req;
  logic                granted_req;
  logic [PW-1:0]       winner;
  logic [PW-1:0]       g_idx;
  logic [PW-1:0]       ptr_after;

  assign req         = m_read | m_write;
  assign any_req     = |req;
  assign granted_req = |(req & grant_reg);
  assign grant       = grant_reg;
  assign ptr_after   = (int'(g_idx) == NMASTERS - 1) ? '0 : g_idx + 1'b1;
  assign chipselect  = (state_reg != IDLE) ? decode_cs : '0;

  // Round-robin scans from the pointer with wrap; fixed priority scans from 0.
  always_comb begin : winner_select
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NMASTERS; k++) begin
      idx = (RR != 0) ? (int'(ptr_reg) + k) % NMASTERS : k;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (grant_reg[i]) g_idx = PW'(i);
    end
  end

  // Bus mux is driven only from the registered grant, so it is glitch-free.
  always_comb begin
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    be        = '0;
    writedata = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (grant_reg[i]) begin
        address   = address | m_address[i*AW +: AW];
        read      = read | m_read[i];
        write     = write | m_write[i];
        be        = be | m_be[i*BW +: BW];
        writedata = writedata | m_writedata[i*DW +: DW];
      end
    end
    if (state_reg == ERR) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      delay_reg <= '0;
      timer_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      delay_reg <= delay_next;
      timer_reg <= timer_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    delay_next = delay_reg;
    timer_next = timer_reg;
    ptr_next   = ptr_reg;
    start      = 1'b0;
    m_wait     = '1;
    m_error    = '0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = NMASTERS'(1) << winner;
          state_next = START;
        end
      end
      START: begin
        start      = 1'b1;
        delay_next = 4'(WAIT_CYCLES);
        timer_next = '0;
        if (!granted_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end else if (decode_cs == '0) begin
          state_next = ERR;
        end else begin
          state_next = PRE;
        end
      end
      PRE: begin
        // Abort and timeout win over completion when they coincide.
        if (!granted_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end else if (TIMEOUT != 0 && timer_reg == 8'(TIMEOUT - 1)) begin
          state_next = ERR;
        end else if (delay_reg == '0 && !slave_wait) begin
          state_next = POST;
        end else begin
          if (delay_reg != '0) delay_next = delay_reg - 1'b1;
          timer_next = timer_reg + 1'b1;
        end
      end
      POST: begin
        m_wait = ~grant_reg;
        if (!granted_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end
      end
      ERR: begin
        m_wait  = ~grant_reg;
        m_error = grant_reg;
        if (!granted_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_multimaster_bus_controller.sv
// Bench for multimaster_bus_controller: a round-robin instance and a fixed-priority
// instance, checked against a transaction-level latency/arbitration model.
`timescale 1ns/1ps
module tb_multimaster_bus_controller;
  localparam int NM  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int NCS = 10;
  localparam int WC0 = 2, RR0 = 1, TO0 = 15;
  localparam int WC1 = 1, RR1 = 0, TO1 = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [NM*AW-1:0] m_address   [2];
  logic [NM-1:0]    m_read      [2];
  logic [NM-1:0]    m_write     [2];
  logic [NM*BW-1:0] m_be        [2];
  logic [NM*DW-1:0] m_writedata [2];
  logic [NM-1:0]    m_wait      [2];
  logic [NM-1:0]    m_error     [2];
  logic [AW-1:0]    address     [2];
  logic             read        [2];
  logic             write       [2];
  logic [BW-1:0]    be          [2];
  logic [DW-1:0]    writedata   [2];
  logic             start       [2];
  logic [NCS-1:0]   chipselect  [2];
  logic [NCS-1:0]   decode_cs   [2];
  logic             slave_wait  [2];
  logic [NM-1:0]    grant       [2];

  int passed = 0;
  int total  = 0;
  int ptr_m [2];

  // External decoder: nibble [23:20] nonzero is unmapped, else one-hot by [15:12].
  function automatic logic [NCS-1:0] decode(input logic [AW-1:0] a);
    logic [NCS-1:0] one;
    one = 1;
    if (a[23:20] != 4'h0) return '0;
    return one << ((int'(a[15:12]) + 5) % NCS);
  endfunction

  assign decode_cs[0] = decode(address[0]);
  assign decode_cs[1] = decode(address[1]);

  multimaster_bus_controller #(
    .NMASTERS(NM), .AW(AW), .DW(DW), .NCS(NCS),
    .WAIT_CYCLES(WC0), .RR(RR0), .TIMEOUT(TO0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m_address(m_address[0]), .m_read(m_read[0]), .m_write(m_write[0]),
    .m_be(m_be[0]), .m_writedata(m_writedata[0]),
    .m_wait(m_wait[0]), .m_error(m_error[0]),
    .address(address[0]), .read(read[0]), .write(write[0]), .be(be[0]),
    .writedata(writedata[0]), .start(start[0]), .chipselect(chipselect[0]),
    .decode_cs(decode_cs[0]), .slave_wait(slave_wait[0]), .grant(grant[0])
  );

  multimaster_bus_controller #(
    .NMASTERS(NM), .AW(AW), .DW(DW), .NCS(NCS),
    .WAIT_CYCLES(WC1), .RR(RR1), .TIMEOUT(TO1)
  ) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .m_address(m_address[1]), .m_read(m_read[1]), .m_write(m_write[1]),
    .m_be(m_be[1]), .m_writedata(m_writedata[1]),
    .m_wait(m_wait[1]), .m_error(m_error[1]),
    .address(address[1]), .read(read[1]), .write(write[1]), .be(be[1]),
    .writedata(writedata[1]), .start(start[1]), .chipselect(chipselect[1]),
    .decode_cs(decode_cs[1]), .slave_wait(slave_wait[1]), .grant(grant[1])
  );

  function automatic int wc(input int inst);
    return (inst == 0) ? WC0 : WC1;
  endfunction
  function automatic int rr(input int inst);
    return (inst == 0) ? RR0 : RR1;
  endfunction
  function automatic int tmo(input int inst);
    return (inst == 0) ? TO0 : TO1;
  endfunction
  function automatic logic [AW-1:0] rand_addr();
    logic [3:0] region;
    region = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'h0;
    return {8'h00, region, 20'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic raise(input int inst, input int m, input logic [AW-1:0] a, input bit wr);
    m_address[inst][m*AW +: AW]   = a;
    m_read[inst][m]               = !wr;
    m_write[inst][m]              = wr;
    m_be[inst][m*BW +: BW]        = 4'($urandom_range(1, 15));
    m_writedata[inst][m*DW +: DW] = $urandom;
  endtask

  task automatic drop(input int inst, input int m);
    m_read[inst][m]  = 1'b0;
    m_write[inst][m] = 1'b0;
  endtask

  // One transaction from the IDLE edge E0 to the return to IDLE; gobs = observed grant.
  task automatic run_txn(input int inst, input int s, input int hold, input int abort_k,
                         input logic [NM-1:0] late, input bit rereq, output int gobs);
    logic [NM-1:0]  mask, g1h;
    logic [AW-1:0]  a;
    logic [NCS-1:0] cs_exp;
    int  g, c, t, ak;
    bit  err, rd, wr, aborted;
    if ((m_read[inst] | m_write[inst]) == '0) raise(inst, 0, 32'h0000_3000, 1'b0);
    mask = m_read[inst] | m_write[inst];
    g = -1;
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (rr(inst) != 0) ? (ptr_m[inst] + k) % NM : k;
      if (g < 0 && mask[i]) g = i;
    end
    g1h = '0;
    g1h[g] = 1'b1;
    a  = m_address[inst][g*AW +: AW];
    rd = m_read[inst][g];
    wr = m_write[inst][g];
    cs_exp = decode(a);
    if (a[23:20] != 4'h0) begin
      t = 1; err = 1'b1;
    end else begin
      c = (s > wc(inst)) ? s : wc(inst);
      if (tmo(inst) != 0 && c >= tmo(inst) - 1) begin
        t = tmo(inst) + 1; err = 1'b1;
      end else begin
        t = c + 2; err = 1'b0;
      end
    end
    ak = (abort_k >= t) ? -1 : abort_k;
    slave_wait[inst] = 1'b0;
    tick();
    gobs = -1;
    for (int i = 0; i < NM; i++) if (grant[inst] == (NM'(1) << i)) gobs = i;
    total++;
    if ({grant[inst], start[inst], chipselect[inst], m_wait[inst]} !== {g1h, 1'b1, cs_exp, {NM{1'b1}}})
      $display("FAIL start_phase inst=%0d grant=%b start=%b cs=%h wait=%b, expected grant=%b start=1 cs=%h wait=1111",
               inst, grant[inst], start[inst], chipselect[inst], m_wait[inst], g1h, cs_exp);
    else passed++;
    total++;
    if ({address[inst], read[inst], write[inst], be[inst], writedata[inst]} !==
        {a, rd, wr, m_be[inst][g*BW +: BW], m_writedata[inst][g*DW +: DW]})
      $display("FAIL bus_mux inst=%0d addr=%h rd=%b wr=%b be=%h wd=%h, expected addr=%h rd=%b wr=%b be=%h wd=%h",
               inst, address[inst], read[inst], write[inst], be[inst], writedata[inst],
               a, rd, wr, m_be[inst][g*BW +: BW], m_writedata[inst][g*DW +: DW]);
    else passed++;
    aborted = 1'b0;
    for (int k = 1; k <= t + hold && !aborted; k++) begin
      if (k == 1) begin
        for (int m = 0; m < NM; m++) if (late[m] && !mask[m]) raise(inst, m, rand_addr(), 1'($urandom));
      end
      slave_wait[inst] = (k - 2 < s);
      tick();
      if (ak >= 0 && k == ak + 1) begin
        aborted = 1'b1;
      end else if (k < t) begin
        total++;
        if ({grant[inst], start[inst], chipselect[inst], m_wait[inst], m_error[inst]} !==
            {g1h, 1'b0, cs_exp, {NM{1'b1}}, {NM{1'b0}}})
          $display("FAIL busy_wait inst=%0d edge=%0d grant=%b start=%b cs=%h wait=%b err=%b, expected grant=%b start=0 cs=%h wait=1111 err=0000",
                   inst, k, grant[inst], start[inst], chipselect[inst], m_wait[inst], m_error[inst], g1h, cs_exp);
        else passed++;
      end else begin
        total++;
        if ({grant[inst], chipselect[inst], m_wait[inst], m_error[inst]} !==
            {g1h, cs_exp, ~g1h, (err ? g1h : {NM{1'b0}})})
          $display("FAIL done_phase inst=%0d edge=%0d grant=%b cs=%h wait=%b err=%b, expected grant=%b cs=%h wait=%b err=%b",
                   inst, k, grant[inst], chipselect[inst], m_wait[inst], m_error[inst],
                   g1h, cs_exp, ~g1h, (err ? g1h : {NM{1'b0}}));
        else passed++;
        total++;
        if ({read[inst], write[inst]} !== (err ? 2'b00 : {rd, wr}))
          $display("FAIL done_rw inst=%0d edge=%0d rd/wr=%b%b, expected %b",
                   inst, k, read[inst], write[inst], (err ? 2'b00 : {rd, wr}));
        else passed++;
      end
      if (k == ak) drop(inst, g);
    end
    if (!aborted) begin
      drop(inst, g);
      tick();
    end
    slave_wait[inst] = 1'b0;
    total++;
    if ({grant[inst], chipselect[inst], start[inst], m_wait[inst], m_error[inst]} !==
        {{NM{1'b0}}, {NCS{1'b0}}, 1'b0, {NM{1'b1}}, {NM{1'b0}}})
      $display("FAIL back_to_idle inst=%0d grant=%b cs=%h start=%b wait=%b err=%b, expected grant=0 cs=0 start=0 wait=1111 err=0",
               inst, grant[inst], chipselect[inst], start[inst], m_wait[inst], m_error[inst]);
    else passed++;
    ptr_m[inst] = (g + 1) % NM;
    if (rereq) raise(inst, g, a, wr);
    $display("txn inst=%0d master=%0d addr=%h %s stretch=%0d abort=%0d error=%0d done_edge=%0d",
             inst, g, a, wr ? "wr" : "rd", s, aborted, err, t);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_read[i] = '1; m_write[i] = '0; slave_wait[i] = 1'b0;
      m_address[i] = {NM{32'h0000_1000}}; m_be[i] = '1; m_writedata[i] = '1;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({grant[i], m_wait[i], m_error[i], address[i], read[i], write[i], be[i], writedata[i], start[i], chipselect[i]} !==
          {{NM{1'b0}}, {NM{1'b1}}, {NM{1'b0}}, {AW{1'b0}}, 2'b00, {BW{1'b0}}, {DW{1'b0}}, 1'b0, {NCS{1'b0}}})
        $display("FAIL reset_state inst=%0d grant=%b wait=%b err=%b addr=%h rd=%b wr=%b start=%b cs=%h, expected all idle",
                 i, grant[i], m_wait[i], m_error[i], address[i], read[i], write[i], start[i], chipselect[i]);
      else passed++;
      m_read[i] = '0; m_write[i] = '0;
    end
    reset_n = 1'b1;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_read();
    int gobs;
    raise(0, 1, 32'h0000_1000, 1'b0);
    run_txn(0, 0, 0, -1, '0, 1'b0, gobs);
    total++;
    if (gobs !== 1) $display("FAIL single_read_grant got=%0d expected=1", gobs);
    else passed++;
  endtask

  task automatic test_arbitration();
    int exp_order [6] = '{0, 2, 3, 0, 2, 3};
    int gobs;
    do_reset();
    raise(0, 0, 32'h0000_2000, 1'b0);
    raise(0, 2, 32'h0000_4000, 1'b1);
    raise(0, 3, 32'h0000_5000, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_txn(0, 0, 0, -1, '0, (n < 3), gobs);
      total++;
      if (gobs !== exp_order[n]) $display("FAIL rr_order step=%0d got=%0d expected=%0d", n, gobs, exp_order[n]);
      else passed++;
    end
  endtask

  task automatic test_fixed_priority();
    int exp_order [5] = '{0, 0, 0, 2, 3};
    int gobs;
    raise(1, 0, 32'h0000_2000, 1'b1);
    raise(1, 2, 32'h0000_4000, 1'b0);
    raise(1, 3, 32'h0000_5000, 1'b0);
    for (int n = 0; n < 5; n++) begin
      run_txn(1, 0, 0, -1, '0, (n < 2), gobs);
      total++;
      if (gobs !== exp_order[n]) $display("FAIL fixed_order step=%0d got=%0d expected=%0d", n, gobs, exp_order[n]);
      else passed++;
    end
  endtask

  task automatic test_stretch();
    int gobs;
    raise(0, 3, 32'h0000_7000, 1'b0);
    run_txn(0, 5, 1, -1, '0, 1'b0, gobs);
  endtask

  task automatic test_timeout();
    int gobs;
    raise(0, 2, 32'h0000_6000, 1'b1);
    run_txn(0, 40, 3, -1, '0, 1'b0, gobs);
    raise(0, 2, 32'h0000_6000, 1'b0);
    raise(0, 3, 32'h0000_8000, 1'b0);
    run_txn(0, 0, 0, -1, '0, 1'b0, gobs);
    total++;
    if (gobs !== 3) $display("FAIL timeout_ptr got=%0d expected=3", gobs);
    else passed++;
    run_txn(0, 0, 0, -1, '0, 1'b0, gobs);
  endtask

  task automatic test_decode_miss();
    int gobs;
    raise(0, 1, 32'h0090_0000, 1'b1);
    run_txn(0, 0, 2, -1, '0, 1'b0, gobs);
  endtask

  task automatic test_abort();
    int gobs;
    raise(0, 0, 32'h0000_9000, 1'b0);
    run_txn(0, 0, 0, 2, '0, 1'b0, gobs);
  endtask

  task automatic test_reset_mid();
    raise(0, 1, 32'h0000_1000, 1'b0);
    tick();
    tick();
    tick();
    total++;
    if ({grant[0], chipselect[0]} !== {4'b0010, 10'h040})
      $display("FAIL pre_reset_busy grant=%b cs=%h, expected grant=0010 cs=040", grant[0], chipselect[0]);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({grant[0], chipselect[0], start[0], m_wait[0], address[0]} !==
        {{NM{1'b0}}, {NCS{1'b0}}, 1'b0, {NM{1'b1}}, {AW{1'b0}}})
      $display("FAIL async_reset grant=%b cs=%h start=%b wait=%b addr=%h, expected grant=0 cs=0 start=0 wait=1111 addr=0",
               grant[0], chipselect[0], start[0], m_wait[0], address[0]);
    else passed++;
    drop(0, 1);
    tick();
    reset_n = 1'b1;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
    tick();
  endtask

  task automatic test_random(input int inst, input int ntxn);
    int gobs, s;
    logic [NM-1:0] late;
    for (int n = 0; n < ntxn; n++) begin
      for (int m = 0; m < NM; m++)
        if (!(m_read[inst][m] | m_write[inst][m]) && $urandom_range(0, 2) == 0)
          raise(inst, m, rand_addr(), 1'($urandom));
      if ((m_read[inst] | m_write[inst]) == '0) raise(inst, $urandom_range(0, NM - 1), rand_addr(), 1'($urandom));
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
      late = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
      run_txn(inst, s, $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : -1,
              late, ($urandom_range(0, 3) == 0), gobs);
    end
    for (int n = 0; n < NM + 1; n++)
      if ((m_read[inst] | m_write[inst]) != '0) run_txn(inst, 0, 0, -1, '0, 1'b0, gobs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_fixed_priority();
    test_stretch();
    test_timeout();
    test_decode_miss();
    test_abort();
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 25);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
